// File: rtl/reduce_pkg.sv
// Shared types and helpers for the serial reduction sequencer.
package reduce_pkg;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } reduce_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   // Identity element of the folding operator; NOR folds as OR and is inverted at the end.
   function automatic logic acc_init(input reduce_op_t op);
      return (op == OP_AND);
   endfunction

   // True once no remaining chunk can change the accumulator.
   function automatic logic is_determined(input reduce_op_t op, input logic acc);
      case (op)
         OP_OR, OP_NOR: return acc;
         OP_AND:        return ~acc;
         default:       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/reduce_serial_ctrl_chunk_reducer.sv
// Combinational CHUNK-bit reduction stage; NOR reduces as OR here.
module chunk_reducer
   import reduce_pkg::*;
#(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] chunk,
   input  reduce_op_t       op,
   output logic             part
);

   always_comb begin
      part = |chunk;
      case (op)
         OP_AND:  part = &chunk;
         OP_XOR:  part = ^chunk;
         default: part = |chunk;
      endcase
   end

endmodule

// File: rtl/reduce_serial_ctrl.sv
// Multi-cycle bitvector reducer: folds one CHUNK-bit slice per cycle into a 1-bit accumulator.
module reduce_serial_ctrl
   import reduce_pkg::*;
#(
   parameter int COUNT_OF_BITS = 16,
   parameter int CHUNK         = 4,
   parameter int EARLY_EXIT    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [COUNT_OF_BITS-1:0] bitvector,
   input  logic [1:0]               op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     reduce,
   output logic                     busy
);

   localparam int NCH = COUNT_OF_BITS / CHUNK;
   localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);

   generate
      if (COUNT_OF_BITS % CHUNK != 0) begin : g_bad_chunk
         $error("COUNT_OF_BITS must be a multiple of CHUNK");
      end
   endgenerate

   state_t                   state_q;
   logic [COUNT_OF_BITS-1:0] shift_q;
   reduce_op_t               op_q;
   logic                     acc_q;
   logic [CW-1:0]            cnt_q;
   logic                     in_ready_q;
   logic                     out_valid_q;
   logic                     reduce_q;
   logic                     busy_q;

   logic                     part;
   logic                     acc_d;
   logic                     finish_d;

   chunk_reducer #(
      .CHUNK (CHUNK)
   ) u_chunk_reducer (
      .chunk (shift_q[CHUNK-1:0]),
      .op    (op_q),
      .part  (part)
   );

   always_comb begin
      acc_d = acc_q | part;
      case (op_q)
         OP_AND:  acc_d = acc_q & part;
         OP_XOR:  acc_d = acc_q ^ part;
         default: acc_d = acc_q | part;
      endcase
      finish_d = (cnt_q == LAST_CHUNK) || ((EARLY_EXIT != 0) && is_determined(op_q, acc_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         op_q        <= OP_OR;
         acc_q       <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         reduce_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready_q) begin
                  state_q    <= RUN;
                  shift_q    <= bitvector;
                  op_q       <= reduce_op_t'(op);
                  acc_q      <= acc_init(reduce_op_t'(op));
                  cnt_q      <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               shift_q <= shift_q >> CHUNK;
               acc_q   <= acc_d;
               cnt_q   <= cnt_q + 1'b1;
               if (finish_d) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
                  reduce_q    <= (op_q == OP_NOR) ? ~acc_d : acc_d;
               end
            end
            DONE: begin
               // in_ready stays low through the handshake edge so a new request waits a cycle.
               if (out_ready) begin
                  state_q     <= IDLE;
                  out_valid_q <= 1'b0;
                  reduce_q    <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               reduce_q    <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign reduce    = reduce_q;
   assign busy      = busy_q;

endmodule

// File: doc/reduce_serial_ctrl.md
Name: reduce_serial_ctrl

Overview:
- Sequencer that time-shares one CHUNK-bit reduction stage across a wide bitvector. It is the multi-cycle alternative to a fully unrolled gate-chain reducer.
- Accepts a vector plus an operation code over a valid/ready handshake.
- Folds the vector chunk by chunk into a 1-bit accumulator, LSB chunk first.
- Presents the 1-bit result over a second valid/ready handshake. Supports early exit for OR/AND/NOR.

Parameters:
- COUNT_OF_BITS, 16, width of input vector; must be a multiple of CHUNK (elaboration-time assertion).
- CHUNK, 4, bits reduced per cycle; NCH = COUNT_OF_BITS/CHUNK.
- EARLY_EXIT, 1, 1 = stop as soon as the result is determined.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- bitvector  in  COUNT_OF_BITS  operand, sampled on the input handshake.
- op  in  2  00 OR, 01 AND, 10 XOR, 11 NOR; sampled on the input handshake.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- reduce  out  1  reduction result.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; reduce=0; busy=0.
  - Shift register, accumulator and chunk counter are cleared.
- States:
  - IDLE: in_ready=1.
  - RUN: in_ready=0, one chunk consumed per cycle.
  - DONE: out_valid=1, reduce held stable.
  - Requests never overlap.
- IDLE -> RUN on in_valid&&in_ready at edge T:
  - Capture bitvector into the shift register and latch op.
  - Chunk counter = 0.
  - Accumulator init: 0 for OR/NOR/XOR, 1 for AND.
- RUN, each edge:
  - part = CHUNK-bit reduction (by latched op; NOR uses OR here) of the shift register's low CHUNK bits.
  - acc <= acc op part; shift register shifts right by CHUNK; counter++.
- RUN -> DONE when either:
  - the consumed chunk had index NCH-1, or
  - EARLY_EXIT=1 and the new acc is determined: OR/NOR with acc=1, AND with acc=0. XOR never exits early.
- Result register (DONE): reduce = acc for OR/AND/XOR, ~acc for NOR.
- Latency:
  - Full run: out_valid first high in cycle T+NCH+1.
  - Early exit at chunk index k: out_valid first high in cycle T+k+2.
- DONE -> IDLE on out_valid&&out_ready.
  - in_ready rises the following cycle, so no same-cycle re-accept.
  - reduce is returned to 0 on that transition.
- Backpressure: while out_ready=0 in DONE, out_valid, reduce and busy hold. in_valid is ignored, with no capture.
- In IDLE, in_valid=0: nothing changes; bitvector/op are don't-care.
- Input values other than those at the handshake edge have no effect.
- Reset mid-RUN or mid-DONE: immediate return to the reset values. The pending result is discarded and never emitted.
- NCH=1 (CHUNK=COUNT_OF_BITS): single RUN cycle; latency 2.

Decomposition:
- Package reduce_pkg holds:
  - reduce_op_t enum (OP_OR, OP_AND, OP_XOR, OP_NOR);
  - state_t enum (IDLE, RUN, DONE);
  - function acc_init(op);
  - function is_determined(op, acc).
- Sub-module chunk_reducer: combinational, parameter CHUNK, inputs chunk[CHUNK-1:0] and op, output part. One instance.
- The FSM, counter, shift register and accumulator live in reduce_serial_ctrl.

Test Plan (COUNT_OF_BITS=16, CHUNK=4, EARLY_EXIT=1, NCH=4, accept at edge T):
1. Full-length OR/NOR:
   - OR, 16'h0000 -> out_valid in cycle T+5, reduce=0, busy high T+1..T+5.
   - NOR, 16'h0000 -> reduce=1 at T+5.
2. OR early exit:
   - OR, 16'h0010 (chunk 1) -> out_valid at T+3, reduce=1.
   - OR, 16'h8000 -> out_valid at T+5, reduce=1.
3. AND:
   - AND, 16'hFFFF -> out_valid at T+5, reduce=1.
   - AND, 16'hFFFE -> out_valid at T+2, reduce=0 (early exit on chunk 0).
4. XOR never exits early:
   - XOR, 16'h8001 -> reduce=0 at T+5.
   - XOR, 16'h8000 -> reduce=1 at T+5.
   - XOR, 16'h0001 -> reduce=1 at T+5.
5. Backpressure:
   - Stimulus: OR 16'h0001 with out_ready=0 for 3 cycles after out_valid rises; hold in_valid=1 with a new vector.
   - Response: out_valid=1 and reduce=1 held, in_ready=0, no capture. Result handshakes when out_ready=1; in_ready=1 next cycle; the next request is then processed correctly.
6. Reset mid-operation:
   - Stimulus: XOR 16'hFFFF, drop rst_n in cycle T+2.
   - Response: immediately in_ready=1, out_valid=0, reduce=0, busy=0; no stale result appears. A subsequent AND 16'hFFFF yields reduce=1 at T'+5.
